// File: rtl/note_recorder.sv
// Transcribes a square-wave tone input into tone/rest/end command words written to song memory.
// Latency: a closed segment is written the cycle after it closes; no backpressure, memory accepts every strobe.
module note_recorder #(
    parameter int TICK_CYCLES    = 750000,
    parameter int SILENCE_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        stop,
    input  logic        tone_in,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [8:0]  length
);

    localparam int HW = ($clog2(SILENCE_CYCLES + 2) > 13) ? $clog2(SILENCE_CYCLES + 2) : 13;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [HW-1:0] SIL_MAX   = HW'(SILENCE_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_FLUSH, S_END} state_t;

    state_t       state_q, state_d;
    logic         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [5:0]   cur_q, cur_d, cand_q, cand_d;
    logic [1:0]   run_q, run_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]   dur_q, dur_d;
    logic         pend_q, pend_d;
    logic [11:0]  pend_dat_q, pend_dat_d;
    logic [7:0]   addr_q, addr_d;
    logic [8:0]   len_q, len_d;

    logic [HW-1:0] meas;
    logic [5:0]   meas_code;
    logic         edge_seen;
    logic         close;

    always_comb begin
        state_d    = state_q;
        sync1_d    = tone_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        hcnt_d     = hcnt_q;
        cur_d      = cur_q;
        cand_d     = cand_q;
        run_d      = run_q;
        tick_d     = tick_q;
        dur_d      = dur_q;
        pend_d     = pend_q;
        pend_dat_d = pend_dat_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wr_en      = 1'b0;
        wr_data    = 12'h000;
        done       = 1'b0;
        close      = 1'b0;

        edge_seen = sync2_q ^ prev_q;
        meas      = hcnt_q + HW'(1);
        if (meas >= HW'(4096)) begin
            meas_code = 6'h3F;
        end else begin
            meas_code = meas[11:6];
        end
        if (meas_code == 6'h00) begin
            meas_code = 6'h01;
        end

        // A new pitch must be seen four times in a row; silence wins at once.
        if (edge_seen) begin
            hcnt_d = '0;
            if (meas_code == cur_q) begin
                run_d = 2'd0;
            end else if (run_q != 2'd0 && meas_code == cand_q) begin
                if (run_q == 2'd3) begin
                    cur_d = meas_code;
                    run_d = 2'd0;
                end else begin
                    run_d = run_q + 2'd1;
                end
            end else begin
                cand_d = meas_code;
                run_d  = 2'd1;
            end
        end else if (hcnt_q != SIL_MAX) begin
            hcnt_d = hcnt_q + HW'(1);
            if (hcnt_d == SIL_MAX) begin
                cur_d = 6'h00;
                run_d = 2'd0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REC;
                    addr_d  = 8'd0;
                    len_d   = 9'd0;
                    cur_d   = 6'h00;
                    run_d   = 2'd0;
                    tick_d  = '0;
                    dur_d   = 4'd0;
                    pend_d  = 1'b0;
                end
            end
            S_REC: begin
                if (pend_q) begin
                    wr_en   = 1'b1;
                    wr_data = pend_dat_q;
                    addr_d  = addr_q + 8'd1;
                    len_d   = len_q + 9'd1;
                    pend_d  = 1'b0;
                end
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    dur_d  = dur_q + 4'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
                close = (cur_d != cur_q) || (dur_q == 4'd15) || stop;
                if (close) begin
                    tick_d = '0;
                    dur_d  = 4'd0;
                    if (dur_q != 4'd0) begin
                        pend_d     = 1'b1;
                        pend_dat_d = (cur_q != 6'h00) ? {2'b10, cur_q, dur_q} : {2'b11, 6'h00, dur_q};
                    end
                end
                // Address 254 holds the last data word so the marker always fits at 255.
                if (pend_q && addr_q == 8'd254) begin
                    state_d = S_END;
                    pend_d  = 1'b0;
                end else if (stop) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pend_q) begin
                    wr_en   = 1'b1;
                    wr_data = pend_dat_q;
                    addr_d  = addr_q + 8'd1;
                    len_d   = len_q + 9'd1;
                    pend_d  = 1'b0;
                end
                state_d = S_END;
            end
            S_END: begin
                wr_en   = 1'b1;
                wr_data = 12'hFFF;
                done    = 1'b1;
                addr_d  = addr_q + 8'd1;
                len_d   = len_q + 9'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_addr = addr_q;
    assign length  = len_q;
    assign busy    = (state_q != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            hcnt_q     <= '0;
            cur_q      <= 6'h00;
            cand_q     <= 6'h00;
            run_q      <= 2'd0;
            tick_q     <= '0;
            dur_q      <= 4'd0;
            pend_q     <= 1'b0;
            pend_dat_q <= 12'h000;
            addr_q     <= 8'd0;
            len_q      <= 9'd0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            hcnt_q     <= hcnt_d;
            cur_q      <= cur_d;
            cand_q     <= cand_d;
            run_q      <= run_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            pend_q     <= pend_d;
            pend_dat_q <= pend_dat_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench: instance a (slow tick) covers tone/long/rest/glitch, instance b (fast tick, short silence) covers full and reset.
module tb_note_recorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start_a = 1'b0, start_b = 1'b0, stop = 1'b0, tone = 1'b0;
    logic        wr_en_a, busy_a, done_a, wr_en_b, busy_b, done_b;
    logic [7:0]  wr_addr_a, wr_addr_b;
    logic [11:0] wr_data_a, wr_data_b;
    logic [8:0]  length_a, length_b;

    note_recorder #(.TICK_CYCLES(1000), .SILENCE_CYCLES(4096)) dut_a (
        .CLK(clk), .RST(rst), .start(start_a), .stop(stop), .tone_in(tone),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .length(length_a)
    );

    note_recorder #(.TICK_CYCLES(60), .SILENCE_CYCLES(32)) dut_b (
        .CLK(clk), .RST(rst), .start(start_b), .stop(stop), .tone_in(tone),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .length(length_b)
    );

    int total = 0;
    int bad   = 0;
    logic [19:0] wq_a[$];
    logic [19:0] wq_b[$];
    int dn_a = 0;
    int dn_b = 0;

    always @(negedge clk) begin
        if (wr_en_a) wq_a.push_back({wr_addr_a, wr_data_a});
        if (wr_en_b) wq_b.push_back({wr_addr_b, wr_data_b});
        if (done_a) dn_a++;
        if (done_b) dn_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wa(input string tag, input int idx, input logic [19:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (idx < wq_a.size()) obs = {12'h000, wq_a[idx]};
        check(tag, obs, {12'h000, exp});
    endtask

    task automatic chk_wb(input string tag, input int idx, input logic [19:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (idx < wq_b.size()) obs = {12'h000, wq_b[idx]};
        check(tag, obs, {12'h000, exp});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic half(input int hp, input int n);
        repeat (n) begin
            cyc(hp);
            tone = ~tone;
        end
    endtask

    // Toggle, start mid-half-period, toggle again: four more toggles at 200 clocks settle code 3.
    task automatic prefix_a();
        tone = ~tone;
        cyc(100);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        cyc(99);
        tone = ~tone;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        check("rst_wr_en", {31'd0, wr_en_a}, 32'd0);
        check("rst_addr", {24'd0, wr_addr_a}, 32'd0);
        check("rst_data", {20'd0, wr_data_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_len", {23'd0, length_a}, 32'd0);
        check("rst_len_b", {23'd0, length_b}, 32'd0);
        rst = 1'b0;
        cyc(20);

        // tone: code 3 for 3 ticks
        wq_a.delete();
        prefix_a();
        check("tone_busy", {31'd0, busy_a}, 32'd1);
        half(200, 20);
        stop_pulse();
        check("tone_flush_en", {31'd0, wr_en_a}, 32'd1);
        check("tone_flush_dat", {20'd0, wr_data_a}, 32'h833);
        check("tone_flush_addr", {24'd0, wr_addr_a}, 32'd0);
        cyc(1);
        check("tone_end_dat", {20'd0, wr_data_a}, 32'hFFF);
        check("tone_end_addr", {24'd0, wr_addr_a}, 32'd1);
        check("tone_done", {31'd0, done_a}, 32'd1);
        cyc(1);
        check("tone_idle_busy", {31'd0, busy_a}, 32'd0);
        check("tone_idle_done", {31'd0, done_a}, 32'd0);
        check("tone_len", {23'd0, length_a}, 32'd2);
        check("tone_nwr", wq_a.size(), 32'd2);
        check("tone_ndone", dn_a, 32'd1);

        // long tone: 20+ ticks splits into 15 + 5
        wq_a.delete();
        prefix_a();
        half(200, 105);
        stop_pulse();
        cyc(4);
        check("long_nwr", wq_a.size(), 32'd3);
        chk_wa("long_w0", 0, {8'd0, 12'h83F});
        chk_wa("long_w1", 1, {8'd1, 12'h835});
        chk_wa("long_w2", 2, {8'd2, 12'hFFF});
        check("long_len", {23'd0, length_a}, 32'd3);

        // stop in idle is ignored; start+stop together starts; start while busy ignored
        wq_a.delete();
        stop_pulse();
        cyc(3);
        check("idle_stop_busy", {31'd0, busy_a}, 32'd0);
        check("idle_stop_nwr", wq_a.size(), 32'd0);
        cyc(50);
        start_a = 1'b1;
        stop = 1'b1;
        cyc(1);
        start_a = 1'b0;
        stop = 1'b0;
        check("start_wins", {31'd0, busy_a}, 32'd1);
        cyc(1000);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        cyc(1499);
        stop_pulse();
        cyc(4);
        check("rest_nwr", wq_a.size(), 32'd2);
        chk_wa("rest_w0", 0, {8'd0, 12'hC02});
        chk_wa("rest_w1", 1, {8'd1, 12'hFFF});

        // glitch: three code-6 half-periods inside a code-3 tone
        wq_a.delete();
        prefix_a();
        half(200, 5);
        half(400, 3);
        half(200, 10);
        stop_pulse();
        cyc(4);
        check("glitch_nwr", wq_a.size(), 32'd2);
        chk_wa("glitch_w0", 0, {8'd0, 12'h833});
        chk_wa("glitch_w1", 1, {8'd1, 12'hFFF});

        // full: alternating 1-tick code-1 tones and rests on instance b
        cyc(100);
        wq_b.delete();
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        for (int p = 0; p < 140; p++) begin
            if (!busy_b) break;
            half(10, 9);
            cyc(90);
        end
        cyc(5);
        check("full_busy", {31'd0, busy_b}, 32'd0);
        check("full_len", {23'd0, length_b}, 32'd256);
        check("full_nwr", wq_b.size(), 32'd256);
        check("full_ndone", dn_b, 32'd1);
        for (int i = 0; i < 256; i++) begin
            logic [11:0] ew;
            ew = (i == 255) ? 12'hFFF : ((i % 2 == 0) ? 12'h811 : 12'hC01);
            chk_wb($sformatf("full_w%0d", i), i, {i[7:0], ew});
        end

        // reset mid-recording after two words
        cyc(100);
        wq_b.delete();
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        half(10, 9);
        cyc(90);
        half(10, 9);
        rst = 1'b1;
        cyc(1);
        check("rstmid_wr_en", {31'd0, wr_en_b}, 32'd0);
        check("rstmid_busy", {31'd0, busy_b}, 32'd0);
        check("rstmid_len", {23'd0, length_b}, 32'd0);
        check("rstmid_addr", {24'd0, wr_addr_b}, 32'd0);
        rst = 1'b0;
        half(10, 9);
        cyc(200);
        check("rstmid_nwr", wq_b.size(), 32'd2);
        chk_wb("rstmid_w0", 0, {8'd0, 12'h811});
        chk_wb("rstmid_w1", 1, {8'd1, 12'hC01});
        check("rstmid_ndone", dn_b, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
